// File: rtl/alsu_cmd_sequencer_pkg.sv
// Shared types for the ALSU command sequencer: command layout, opcodes, FSM states.
package alsu_cmd_sequencer_pkg;

  localparam int CMD_W  = 16;
  localparam int OUT_W  = 6;
  localparam int LEDS_W = 16;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND    = 3'd0,
    OP_XOR    = 3'd1,
    OP_ADD    = 3'd2,
    OP_MUL    = 3'd3,
    OP_SHIFT  = 3'd4,
    OP_ROTATE = 3'd5
  } alsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } seq_state_e;

  // Field order matches the packed command word, MSB first: A at [15:13] down to direction at [0].
  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic [OP_W-1:0] opcode;
    logic            cin;
    logic            serial_in;
    logic            red_op_a;
    logic            red_op_b;
    logic            bypass_a;
    logic            bypass_b;
    logic            direction;
  } alsu_cmd_t;

  function automatic alsu_cmd_t unpack_cmd(input logic [CMD_W-1:0] raw);
    return alsu_cmd_t'(raw);
  endfunction

endpackage

// File: rtl/alsu_cmd_sequencer_if.sv
// Host-side command/response handshake bundle for the ALSU command sequencer.
interface alsu_cmd_sequencer_if;
  import alsu_cmd_sequencer_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [CMD_W-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [OUT_W-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/alsu_cmd_sequencer_fifo.sv
// Show-ahead synchronous command FIFO; rd_data is the current head, pop advances it.
module alsu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  // Callers guarantee push only when !full and pop only when !empty; pointers wrap as DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/alsu_cmd_sequencer.sv
// Buffers host commands, issues them one at a time to the ALSU, waits out its pipeline, returns in-order responses.
// Define ALSU_SEQ_ERR_DETECT_EN to report nonzero alsu_leds at capture as rsp_err.
module alsu_cmd_sequencer
  import alsu_cmd_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ALSU_LAT   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  alsu_cmd_sequencer_if.slave           bus,
  output logic [OP_W-1:0]               A,
  output logic [OP_W-1:0]               B,
  output logic [OP_W-1:0]               opcode,
  output logic                          cin,
  output logic                          serial_in,
  output logic                          red_op_A,
  output logic                          red_op_B,
  output logic                          bypass_A,
  output logic                          bypass_B,
  output logic                          direction,
  input  logic [OUT_W-1:0]              alsu_out,
  input  logic [LEDS_W-1:0]             alsu_leds,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CNT_W = (ALSU_LAT < 1) ? 1 : $clog2(ALSU_LAT + 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  alsu_cmd_t        drive_q, drive_d;
  logic [OUT_W-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;
  logic             ready_q;

  logic             push, pop;
  logic             fifo_full, fifo_empty;
  logic [CMD_W-1:0] fifo_head;
  logic             err_sample;

`ifdef ALSU_SEQ_ERR_DETECT_EN
  assign err_sample = |alsu_leds;
`else
  logic unused_leds;
  assign unused_leds = ^alsu_leds;
  assign err_sample  = 1'b0;
`endif

  // ready_q keeps cmd_ready low while in reset; afterwards ready tracks !full without a pop bypass.
  assign bus.cmd_ready = ready_q & ~fifo_full;
  assign push          = bus.cmd_valid & bus.cmd_ready;

  alsu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (bus.cmd_data),
    .pop     (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drive_d     = drive_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = rsp_valid_q;
    pop         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          drive_d = unpack_cmd(fifo_head);
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // cnt_q == ALSU_LAT on the edge ALSU_LAT+1 after issue, when alsu_out reflects the issued command.
        if (cnt_q == CNT_W'(ALSU_LAT)) begin
          rsp_data_d  = alsu_out;
          rsp_err_d   = err_sample;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      drive_q     <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drive_q     <= drive_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      ready_q     <= 1'b1;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = busy_q;

  assign A         = drive_q.a;
  assign B         = drive_q.b;
  assign opcode    = drive_q.opcode;
  assign cin       = drive_q.cin;
  assign serial_in = drive_q.serial_in;
  assign red_op_A  = drive_q.red_op_a;
  assign red_op_B  = drive_q.red_op_b;
  assign bypass_A  = drive_q.bypass_a;
  assign bypass_B  = drive_q.bypass_b;
  assign direction = drive_q.direction;

endmodule

// File: tb/tb_alsu_cmd_sequencer.sv
// Scoreboard bench for alsu_cmd_sequencer with a two-stage ALSU stand-in; honours ALSU_SEQ_ERR_DETECT_EN.
module tb_alsu_cmd_sequencer;
  import alsu_cmd_sequencer_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alsu_cmd_sequencer_if bus();

  logic [2:0]  A, B, opcode;
  logic        cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction;
  logic [5:0]  alsu_out  = '0;
  logic [15:0] alsu_leds = '0;
  logic        busy;
  logic [2:0]  fifo_count;

  alsu_cmd_sequencer #(.FIFO_DEPTH(4), .ALSU_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .A(A), .B(B), .opcode(opcode), .cin(cin), .serial_in(serial_in),
    .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .direction(direction), .alsu_out(alsu_out), .alsu_leds(alsu_leds),
    .busy(busy), .fifo_count(fifo_count)
  );

  // Behavioural ALSU: {leds, out}. Invalid ops (6/7, or reduction with an arithmetic op) blink leds and give 0.
  function automatic logic [21:0] alsu_func(input logic [15:0] c);
    logic [2:0] a, b, op;
    logic [5:0] o;
    a = c[15:13]; b = c[12:10]; op = c[9:7];
    o = '0;
    if ((op > 3'd5) || ((c[4] || c[3]) && (op > 3'd1))) return {16'hFFFF, 6'd0};
    if (c[2])      o = {3'b0, a};
    else if (c[1]) o = {3'b0, b};
    else begin
      case (op)
        OP_AND:  o = c[4] ? {5'b0, &a} : (c[3] ? {5'b0, &b} : {3'b0, a & b});
        OP_XOR:  o = c[4] ? {5'b0, ^a} : (c[3] ? {5'b0, ^b} : {3'b0, a ^ b});
        OP_ADD:  o = {3'b0, a} + {3'b0, b} + {5'b0, c[6]};
        OP_MUL:  o = {3'b0, a} * {3'b0, b};
        default: o = '0;
      endcase
    end
    return {16'h0000, o};
  endfunction

  logic [15:0] pins;
  logic [15:0] stage1 = '0;
  assign pins = {A, B, opcode, cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction};

  always @(posedge clk) begin
    stage1 <= pins;
    {alsu_leds, alsu_out} <= alsu_func(stage1);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] cmd;
    logic [5:0]  out;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic exp_t make_exp(input logic [15:0] c);
    exp_t        e;
    logic [21:0] r;
    r     = alsu_func(c);
    e.cmd = c;
    e.out = r[5:0];
`ifdef ALSU_SEQ_ERR_DETECT_EN
    e.err = (r[21:6] != 16'h0);
`else
    e.err = 1'b0;
`endif
    return e;
  endfunction

  function automatic logic [15:0] rand_cmd();
    logic [15:0] c;
    int          k;
    c = 16'($urandom);
    k = $urandom_range(0, 5);
    c[9:7] = (k < 4) ? 3'(k) : 3'(k + 2);
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge, cmd_valid still high.
  task automatic send_cmd(input logic [15:0] c);
    bit ok;
    ok = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = c;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) ok = 1'b1;
    end
    if (ok) begin
      exp_q.push_back(make_exp(c));
      tick();
      $display("[TB] cmd 0x%04h accepted at cycle %0d", c, cyc);
    end else begin
      tests++;
      fails++;
      $display("FAIL cmd_accept_timeout: cmd 0x%04h not accepted in 200 cycles", c);
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: %0d responses outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic monitor();
    bit         hold_v;
    logic [6:0] hold_val;
    exp_t       e;
    hold_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
      end else if (bus.rsp_valid) begin
        if (hold_v) check("rsp_hold", 32'({bus.rsp_data, bus.rsp_err}), 32'(hold_val));
        if (bus.rsp_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_rsp: got rsp_data 0x%0h with no command outstanding", bus.rsp_data);
          end else begin
            e = exp_q.pop_front();
            check("rsp_data", 32'(bus.rsp_data), 32'(e.out));
            check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            check("alsu_pins", 32'(pins), 32'(e.cmd));
            $display("[TB] rsp cmd=0x%04h data=%0d err=%0b", e.cmd, bus.rsp_data, bus.rsp_err);
          end
          hold_v = 1'b0;
        end else begin
          hold_v   = 1'b1;
          hold_val = {bus.rsp_data, bus.rsp_err};
        end
      end
    end
  endtask

  initial begin
    int  accept_cyc;
    bit  seen;
    bit  lat_ok;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 16'h7540;
    bus.rsp_ready = 1'b0;
    fork
      monitor();
    join_none

    // Reset with a command offered
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_pins", 32'(pins), 32'd0);
    check("reset_fifo_count", 32'(fifo_count), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    tick();
    bus.cmd_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_reset", 32'(bus.cmd_ready), 32'd1);
    tick();

    // ADD with carry, latency from accept to rsp_valid
    bus.rsp_ready = 1'b1;
    send_cmd(16'h7540);
    accept_cyc = cyc;
    bus.cmd_valid = 1'b0;
    lat_ok = 1'b0;
    for (int i = 0; i < 20 && !lat_ok; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) lat_ok = 1'b1;
    end
    check("latency", 32'(cyc - accept_cyc), 32'd4);
    tick();
    drain("add");

    // MUL, then drive pins must hold the issued command while idle
    send_cmd(16'hF980);
    bus.cmd_valid = 1'b0;
    drain("mul");
    repeat (3) tick();
    check("pins_hold_idle", 32'({A, B, opcode}), 32'h1F3);

    // Backpressure: 5 accepted (4 buffered + 1 in flight), 6th refused
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_cmd(rand_cmd());
    bus.cmd_data = rand_cmd();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) seen = 1'b1;
    end
    check("sixth_cmd_ready", 32'(seen), 32'd0);
    check("full_fifo_count", 32'(fifo_count), 32'd4);
    check("full_busy", 32'(busy), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    repeat (4) tick();
    bus.rsp_ready = 1'b1;
    drain("backpressure");

    // Invalid opcode 7
    send_cmd(16'h0380);
    bus.cmd_valid = 1'b0;
    drain("invalid_op");

    // Randomized traffic with random response backpressure
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          send_cmd(rand_cmd());
          if ($urandom_range(0, 2) == 0) begin
            bus.cmd_valid = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
          end
        end
        bus.cmd_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 400; k++) begin
          tick();
          bus.rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.rsp_ready = 1'b1;
    drain("random");

    // Reset while a command is in WAIT and another is buffered
    send_cmd(rand_cmd());
    send_cmd(rand_cmd());
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("wait_busy", 32'(busy), 32'd1);
    check("wait_fifo_count", 32'(fifo_count), 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    check("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midreset_fifo_count", 32'(fifo_count), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    check("post_reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("post_reset_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
